signed_unary_unit: RTL



---
 rtl/signed_unary_pkg.sv | 29 ++
 rtl/signed_unary_core.sv | 69 ++++++
 rtl/signed_unary_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/signed_unary_pkg.sv
// Shared types and helpers for the signed unary unit: opcode encoding, output buffer depth,
// and MIN/MAX constants. The MIN/MAX helpers return a wide vector that callers truncate to their own width.
package signed_unary_pkg;

    typedef enum logic [2:0] {
        OP_NEG  = 3'd0,
        OP_NOT  = 3'd1,
        OP_LNOT = 3'd2,
        OP_RAND = 3'd3,
        OP_ROR  = 3'd4,
        OP_RXOR = 3'd5,
        OP_ABS  = 3'd6,
        OP_SIGN = 3'd7
    } op_e;

    localparam int BUF_DEPTH = 2;
    localparam int MAX_WIDTH = 64;

    // The most negative value: 1 followed by w-1 zeros.
    function automatic logic [MAX_WIDTH-1:0] su_min(input int unsigned w);
        return MAX_WIDTH'(1) << (w - 1);
    endfunction

    // The most positive value: 0 followed by w-1 ones.
    function automatic logic [MAX_WIDTH-1:0] su_max(input int unsigned w);
        return (MAX_WIDTH'(1) << (w - 1)) - MAX_WIDTH'(1);
    endfunction

endpackage

// File: rtl/signed_unary_core.sv
// Combinational signed unary operator: maps {op, data} to {result, ovf}.
// Defining SIGNED_UNARY_SAT_EN makes NEG/ABS of MIN saturate to MAX instead of wrapping.
module signed_unary_core
    import signed_unary_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e                      op,
    input  logic signed [WIDTH-1:0]  data,
    output logic signed [WIDTH-1:0]  result,
    output logic                     ovf
);

    localparam logic signed [WIDTH-1:0] MIN_VAL = WIDTH'(su_min(WIDTH));
    localparam logic signed [WIDTH-1:0] MAX_VAL = WIDTH'(su_max(WIDTH));

    // Value substituted when negating MIN cannot be represented.
    function automatic logic signed [WIDTH-1:0] overflow_value();
`ifdef SIGNED_UNARY_SAT_EN
        return MAX_VAL;
`else
        return MIN_VAL;
`endif
    endfunction

    logic is_min;

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        is_min = (data == MIN_VAL);
        case (op)
            OP_NEG: begin
                if (is_min) begin
                    result = overflow_value();
                    ovf    = 1'b1;
                end else begin
                    result = -data;
                end
            end
            OP_NOT:  result = ~data;
            OP_LNOT: result = {{(WIDTH-1){1'b0}}, ~(|data)};
            OP_RAND: result = {{(WIDTH-1){1'b0}}, &data};
            OP_ROR:  result = {{(WIDTH-1){1'b0}}, |data};
            OP_RXOR: result = {{(WIDTH-1){1'b0}}, ^data};
            OP_ABS: begin
                if (is_min) begin
                    result = overflow_value();
                    ovf    = 1'b1;
                end else if (data[WIDTH-1]) begin
                    result = -data;
                end else begin
                    result = data;
                end
            end
            OP_SIGN: begin
                if (data[WIDTH-1]) begin
                    result = '1;
                end else if (|data) begin
                    result = WIDTH'(1);
                end else begin
                    result = '0;
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/signed_unary_unit.sv
// Streaming signed unary unit: valid/ready input, 2-entry result buffer, saturating overflow counter.
// Optional build macro SIGNED_UNARY_SAT_EN selects saturation of NEG/ABS of MIN (see signed_unary_core).
module signed_unary_unit
    import signed_unary_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int OVF_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic signed [WIDTH-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [WIDTH-1:0]  out_data,
    output logic                     out_ovf,
    input  logic                     ovf_clr,
    output logic [OVF_CNT_W-1:0]     ovf_count
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = $clog2(BUF_DEPTH);

    typedef struct packed {
        logic signed [WIDTH-1:0] data;
        logic                    ovf;
    } entry_t;

    logic signed [WIDTH-1:0] core_result;
    logic                    core_ovf;

    signed_unary_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (op_e'(in_op)),
        .data   (in_data),
        .result (core_result),
        .ovf    (core_ovf)
    );

    entry_t               mem_q [BUF_DEPTH];
    entry_t               mem_d [BUF_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic                 in_ready_q, in_ready_d;
    logic [OVF_CNT_W-1:0] ovf_count_q, ovf_count_d;
    logic                 push, pop;

    assign in_ready  = in_ready_q;
    assign out_valid = (occ_q != '0);
    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;
    assign ovf_count = ovf_count_q;

    // Buffer storage is not reset, so the head is masked to zero whenever nothing is held.
    assign out_data = out_valid ? mem_q[rd_ptr_q].data : '0;
    assign out_ovf  = out_valid ? mem_q[rd_ptr_q].ovf  : 1'b0;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{data: core_result, ovf: core_ovf};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        occ_d      = occ_q + OCC_W'(push) - OCC_W'(pop);
        in_ready_d = (occ_d < OCC_W'(BUF_DEPTH));
    end

    // A clear wins over accumulation, but an overflow accepted in the same cycle still counts.
    always_comb begin
        ovf_count_d = ovf_count_q;
        if (ovf_clr) begin
            ovf_count_d = (push && core_ovf) ? OVF_CNT_W'(1) : '0;
        end else if (push && core_ovf && (ovf_count_q != '1)) begin
            ovf_count_d = ovf_count_q + OVF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            in_ready_q  <= 1'b1;
            ovf_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            in_ready_q  <= in_ready_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
